// File: rtl/vga_pkg.sv
// Shared VGA definitions: active area, replication factor, scanout latency,
// the 12-bit colour type and the sideband record carried down the delay line.
package vga_pkg;

   localparam int HACTIVE     = 1024;
   localparam int VACTIVE     = 768;
   localparam int SCALE_SHIFT = 2;
   localparam int SCANOUT_LAT = 3;
   localparam int PAL_DEPTH   = 16;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef struct packed {
      logic vidon;
      logic hsync;
      logic vsync;
      logic first;
   } sideband_t;

   // Blanking, syncs released, not the first pixel.
   localparam sideband_t SB_IDLE = '{vidon: 1'b0, hsync: 1'b1, vsync: 1'b1, first: 1'b0};

   function automatic rgb12_t grey(input logic [3:0] i);
      return '{r: i, g: i, b: i};
   endfunction

endpackage

// File: rtl/vga_palette.sv
// 16-entry colour register file: one write port, one registered read port.
// Reset loads a greyscale ramp; a disabled read returns black.
module vga_palette
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_idx,
   input  rgb12_t     wr_rgb,
   input  logic       rd_en,
   input  logic [3:0] rd_idx,
   output rgb12_t     rd_rgb
);

   rgb12_t mem [PAL_DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PAL_DEPTH; i++) begin
            mem[i] <= grey(4'(i));
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_rgb;
      end
   end

   // Reads sample the array before this edge's write lands: same-edge returns old colour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_rgb <= '0;
      end else if (rd_en) begin
         rd_rgb <= mem[rd_idx];
      end else begin
         rd_rgb <= '0;
      end
   end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout stage: timing-generator coordinates in, palette-mapped
// colour out, with syncs delayed to stay aligned with the colour pins.
module vga_fb_scanout
   import vga_pkg::*;
#(
   parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
   parameter int FB_AW       = 16,
   parameter int LAT         = SCANOUT_LAT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      x,
   input  logic [9:0]       y,
   input  logic             vidon,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [FB_AW-1:0] fb_addr,
   input  logic [3:0]       fb_rdata,
   input  logic             pal_wr_valid,
   input  logic [3:0]       pal_wr_idx,
   input  logic [11:0]      pal_wr_rgb,
   output logic             pal_wr_ready,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b,
   output logic             hsync,
   output logic             vsync,
   output logic             vidon_out,
   output logic             frame_start,
   output logic [7:0]       frame_cnt
);

   logic [FB_AW-1:0] addr_next;
   sideband_t        sb_in;
   sideband_t        sb [LAT];
   rgb12_t           pix;
   logic             pal_wr_en;

   // Palette write handshake: a request is taken on any edge where
   // pal_wr_valid & pal_wr_ready; until then the requester holds valid and
   // its idx/rgb stable. Ready only outside active video and out of reset.
   assign pal_wr_ready = ~vidon & ~reset;
   assign pal_wr_en    = pal_wr_valid & pal_wr_ready;

   always_comb begin
      addr_next = '0;
      if (vidon) begin
         addr_next = FB_AW'({y[9:SCALE_SHIFT], x[9:SCALE_SHIFT]});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_addr <= '0;
      end else begin
         fb_addr <= addr_next;
      end
   end

   always_comb begin
      sb_in       = SB_IDLE;
      sb_in.vidon = vidon;
      sb_in.hsync = hsync_in;
      sb_in.vsync = vsync_in;
      sb_in.first = (x == '0) && (y == '0);
   end

   // Sideband delay line; the RAM read and palette lookup fill the same three stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            sb[i] <= SB_IDLE;
         end
      end else begin
         sb[0] <= sb_in;
         for (int i = 1; i < LAT; i++) begin
            sb[i] <= sb[i-1];
         end
      end
   end

   vga_palette u_palette (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (pal_wr_en),
      .wr_idx (pal_wr_idx),
      .wr_rgb (rgb12_t'(pal_wr_rgb)),
      .rd_en  (sb[LAT-2].vidon),
      .rd_idx (fb_rdata),
      .rd_rgb (pix)
   );

   // Counts on the edge that loads the flag into the last stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (sb[LAT-2].first) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign r           = pix.r;
   assign g           = pix.g;
   assign b           = pix.b;
   assign hsync       = sb[LAT-1].hsync;
   assign vsync       = sb[LAT-1].vsync;
   assign vidon_out   = sb[LAT-1].vidon;
   assign frame_start = sb[LAT-1].first;

endmodule
